square_64b_seq: RTL

- Iterative squarer, the inverse operator of the 128b→64b integer square root benchmark.
- Takes an unsigned WIDTH-bit operand and returns its exact 2*WIDTH-bit square over several cycles, using a radix-2^BITS_PER_CYCLE shift-add datapath.
- Used as the round-trip companion for sqrt circuits: out0 of sqrt feeds in0 here, and the result is compared against the original 128-bit input.
- Valid/ready handshakes on both sides.

---
 rtl/square_64b_seq_if.sv | 24 ++
 rtl/square_64b_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/square_64b_seq_if.sv
// Handshake bundle for square_64b_seq: operand channel, result channel and
// the busy status flag. The master side is the producer/consumer of data,
// the slave side is the squarer itself.
interface square_64b_seq_if #(
  parameter int WIDTH = 64
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in0;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out0;
  logic               busy;

  modport master (
    output in_valid, in0, out_ready,
    input  in_ready, out_valid, out0, busy
  );

  modport slave (
    input  in_valid, in0, out_ready,
    output in_ready, out_valid, out0, busy
  );
endinterface

// File: rtl/square_64b_seq.sv
// square_64b_seq: iterative unsigned squarer, WIDTH-bit operand to exact
// 2*WIDTH-bit result, retiring BITS_PER_CYCLE multiplier bits per cycle with
// a shift-add datapath. Valid/ready handshakes on both sides.
//
// Optional build macro SQUARE_EARLY_EXIT_EN: when defined, the calculation
// stops as soon as the remaining multiplier bits are all zero, giving a
// latency that tracks the operand magnitude. Results are identical either way.
module square_64b_seq #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  square_64b_seq_if.slave  bus
);

  localparam int RES_W = 2 * WIDTH;
  localparam int N_ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N_ITER + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_ITER);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if ((BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
      $error("square_64b_seq: BITS_PER_CYCLE must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  // Small-digit multiple of the shifted multiplicand: sum of M<<k for each
  // set bit k of the digit. Truncated to the result width; the exact square
  // never exceeds it.
  function automatic logic [RES_W-1:0] partial_product(
    input logic [RES_W-1:0]          m,
    input logic [BITS_PER_CYCLE-1:0] d
  );
    logic [RES_W-1:0] pp;
    pp = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (d[k]) pp = pp + (m << k);
    end
    return pp;
  endfunction

  state_t           state_q, state_d;
  logic [RES_W-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] out0_q, out0_d;

  logic [RES_W-1:0] acc_nxt;
  logic [WIDTH-1:0] q_shift;
  logic             last_iter;
  logic             calc_exit;

  assign acc_nxt   = acc_q + partial_product(m_q, q_q[BITS_PER_CYCLE-1:0]);
  assign q_shift   = q_q >> BITS_PER_CYCLE;
  assign last_iter = (cnt_q == CNT_ONE);

`ifdef SQUARE_EARLY_EXIT_EN
  assign calc_exit = last_iter | (q_shift == '0);
`else
  assign calc_exit = last_iter;
`endif

  // State and datapath registers; async reset clears everything, result included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out0_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out0_q  <= out0_d;
    end
  end

  // Next-state and datapath update; out0 is written only on entry to DONE.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out0_d  = out0_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          m_d     = {{WIDTH{1'b0}}, bus.in0};
          q_d     = bus.in0;
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_nxt;
        m_d   = m_q << BITS_PER_CYCLE;
        q_d   = q_shift;
        cnt_d = cnt_q - CNT_ONE;
        if (calc_exit) begin
          out0_d  = acc_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE) & ~rst;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out0      = out0_q;

endmodule
